// File: rtl/hue_sweep_sequencer.sv
// Colour-wheel sweep sequencer: steps R/G/B duty words around six 60-degree sectors
// and publishes every new duty triple to the PWM bank over a valid/ready handshake.
module hue_sweep_sequencer #(
    parameter int STEP_CYCLES      = 20000,
    parameter int STEPS_PER_SECTOR = 100,
    parameter int DUTY_MAX         = 1200,
    parameter int DUTY_W           = $clog2(DUTY_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              restart,
    input  logic              upd_ready,
    output logic              upd_valid,
    output logic [DUTY_W-1:0] duty_r,
    output logic [DUTY_W-1:0] duty_g,
    output logic [DUTY_W-1:0] duty_b,
    output logic [2:0]        sector,
    output logic              sector_done
);

    localparam int STEP = DUTY_MAX / STEPS_PER_SECTOR;
    localparam int PW   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int SW   = (STEPS_PER_SECTOR > 1) ? $clog2(STEPS_PER_SECTOR) : 1;

    localparam logic [PW-1:0]     PRESC_TC = PW'(STEP_CYCLES - 1);
    localparam logic [SW-1:0]     STEP_TC  = SW'(STEPS_PER_SECTOR - 1);
    localparam logic [DUTY_W-1:0] MAX_W    = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] STEP_W   = DUTY_W'(STEP);
    localparam logic [DUTY_W-1:0] ZERO_W   = '0;

    // A non-integer step would leave the ramp short of full-on at the sector edge.
    generate
        if (DUTY_MAX % STEPS_PER_SECTOR != 0) begin : g_bad_step
            $error("DUTY_MAX must be a multiple of STEPS_PER_SECTOR");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [SW-1:0]     step_q, step_d;
    logic [2:0]        sector_q, sector_d;
    logic [DUTY_W-1:0] duty_r_q, duty_r_d;
    logic [DUTY_W-1:0] duty_g_q, duty_g_d;
    logic [DUTY_W-1:0] duty_b_q, duty_b_d;
    logic              upd_valid_q, upd_valid_d;
    logic              sector_done_q, sector_done_d;

    logic              at_tc;
    logic              step_evt;
    logic              sector_wrap;
    logic [SW-1:0]     step_nx;
    logic [2:0]        sector_nx;
    logic [DUTY_W-1:0] up, dn;
    logic [DUTY_W-1:0] tab_r, tab_g, tab_b;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            presc_q       <= '0;
            step_q        <= '0;
            sector_q      <= '0;
            duty_r_q      <= MAX_W;
            duty_g_q      <= '0;
            duty_b_q      <= '0;
            upd_valid_q   <= 1'b0;
            sector_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            step_q        <= step_d;
            sector_q      <= sector_d;
            duty_r_q      <= duty_r_d;
            duty_g_q      <= duty_g_d;
            duty_b_q      <= duty_b_d;
            upd_valid_q   <= upd_valid_d;
            sector_done_q <= sector_done_d;
        end
    end

    assign at_tc    = (presc_q == PRESC_TC);
    assign step_evt = en && (state_q != IDLE) && at_tc && (!upd_valid_q || upd_ready);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN: begin
                if (!en)
                    state_d = IDLE;
                else if (at_tc && upd_valid_q && !upd_ready)
                    state_d = STALL;
            end
            STALL: begin
                if (!en)
                    state_d = IDLE;
                else if (upd_ready)
                    state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
        if (restart)
            state_d = en ? RUN : IDLE;
    end

    // Colour-wheel table evaluated at the position the next step event lands on.
    always_comb begin
        sector_wrap = (step_q == STEP_TC);
        step_nx     = sector_wrap ? '0 : step_q + 1'b1;
        sector_nx   = sector_q;
        if (sector_wrap)
            sector_nx = (sector_q == 3'd5) ? 3'd0 : sector_q + 3'd1;
        up = DUTY_W'(step_nx) * STEP_W;
        dn = MAX_W - up;
        tab_r = ZERO_W;
        tab_g = ZERO_W;
        tab_b = ZERO_W;
        case (sector_nx)
            3'd0:    begin tab_r = MAX_W;  tab_g = up;     tab_b = ZERO_W; end
            3'd1:    begin tab_r = dn;     tab_g = MAX_W;  tab_b = ZERO_W; end
            3'd2:    begin tab_r = ZERO_W; tab_g = MAX_W;  tab_b = up;     end
            3'd3:    begin tab_r = ZERO_W; tab_g = dn;     tab_b = MAX_W;  end
            3'd4:    begin tab_r = up;     tab_g = ZERO_W; tab_b = MAX_W;  end
            default: begin tab_r = MAX_W;  tab_g = ZERO_W; tab_b = dn;     end
        endcase
    end

    // Output / datapath logic
    always_comb begin
        presc_d       = presc_q;
        step_d        = step_q;
        sector_d      = sector_q;
        duty_r_d      = duty_r_q;
        duty_g_d      = duty_g_q;
        duty_b_d      = duty_b_q;
        upd_valid_d   = upd_valid_q && !upd_ready;
        sector_done_d = 1'b0;

        if (restart) begin
            presc_d     = '0;
            step_d      = '0;
            sector_d    = 3'd0;
            duty_r_d    = MAX_W;
            duty_g_d    = ZERO_W;
            duty_b_d    = ZERO_W;
            upd_valid_d = 1'b1;
        end else if (step_evt) begin
            presc_d       = '0;
            step_d        = step_nx;
            sector_d      = sector_nx;
            duty_r_d      = tab_r;
            duty_g_d      = tab_g;
            duty_b_d      = tab_b;
            upd_valid_d   = 1'b1;
            sector_done_d = sector_wrap;
        end else if (state_q == IDLE || !en) begin
            presc_d = '0;
        end else if (state_q == RUN && !at_tc) begin
            presc_d = presc_q + 1'b1;
        end
    end

    assign upd_valid   = upd_valid_q;
    assign duty_r      = duty_r_q;
    assign duty_g      = duty_g_q;
    assign duty_b      = duty_b_q;
    assign sector      = sector_q;
    assign sector_done = sector_done_q;

endmodule

// File: tb/tb_hue_sweep_sequencer.sv
// Scoreboard bench for hue_sweep_sequencer with a short 4-clock step and 4 steps per sector.
module tb_hue_sweep_sequencer;

    localparam int SC  = 4;
    localparam int SPS = 4;
    localparam int DM  = 12;
    localparam int DW  = $clog2(DM + 1);

    logic          clk;
    logic          rst;
    logic          en;
    logic          restart;
    logic          upd_ready;
    logic          upd_valid;
    logic [DW-1:0] duty_r, duty_g, duty_b;
    logic [2:0]    sector;
    logic          sector_done;

    hue_sweep_sequencer #(
        .STEP_CYCLES     (SC),
        .STEPS_PER_SECTOR(SPS),
        .DUTY_MAX        (DM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .restart    (restart),
        .upd_ready  (upd_ready),
        .upd_valid  (upd_valid),
        .duty_r     (duty_r),
        .duty_g     (duty_g),
        .duty_b     (duty_b),
        .sector     (sector),
        .sector_done(sector_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    int m_sec = 0;
    int m_st  = 0;
    int cyc   = 0;
    int last_xfer = -1;
    bit spacing_on = 1'b0;
    int sd_count = 0;
    bit ovf = 1'b0;

    task automatic check(input string tag, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, want, want);
        end
    endtask

    function automatic int exp_word(input int sec, input int st);
        int up, dn, r, g, b;
        up = st * (DM / SPS);
        dn = DM - up;
        case (sec)
            0:       begin r = DM; g = up; b = 0;  end
            1:       begin r = dn; g = DM; b = 0;  end
            2:       begin r = 0;  g = DM; b = up; end
            3:       begin r = 0;  g = dn; b = DM; end
            4:       begin r = up; g = 0;  b = DM; end
            default: begin r = DM; g = 0;  b = dn; end
        endcase
        return (sec << 24) | (r << 16) | (g << 8) | b;
    endfunction

    function automatic int dut_word();
        return (int'(sector) << 24) | (int'(duty_r) << 16) | (int'(duty_g) << 8) | int'(duty_b);
    endfunction

    task automatic expect_steps(input int n);
        for (int i = 0; i < n; i++) begin
            if (m_st == SPS - 1) begin
                m_st  = 0;
                m_sec = (m_sec == 5) ? 0 : m_sec + 1;
            end else begin
                m_st++;
            end
            exp_q.push_back(exp_word(m_sec, m_st));
        end
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, exp_q.size(), 0);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!upd_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid_wait"}, int'(upd_valid), 1);
    endtask

    // Transfer monitor: pops the scoreboard on every accepted update.
    initial begin
        int e;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                if (sector_done) sd_count++;
                if (duty_r > DM || duty_g > DM || duty_b > DM) ovf = 1'b1;
                if (upd_valid && upd_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_xfer", dut_word(), -1);
                    end else begin
                        e = exp_q.pop_front();
                        $display("xfer cyc=%0d sector=%0d r=%0d g=%0d b=%0d", cyc, sector, duty_r, duty_g, duty_b);
                        check("xfer", dut_word(), e);
                    end
                    if (spacing_on) begin
                        if (last_xfer >= 0) check("xfer_gap", cyc - last_xfer, SC);
                        last_xfer = cyc;
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b0; en = 1'b0; restart = 1'b0; upd_ready = 1'b0;

        // Asynchronous reset takes effect without any clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst_duty", dut_word(), exp_word(0, 0));
        check("rst_valid", int'(upd_valid), 0);
        check("rst_sector_done", int'(sector_done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Full hue cycle with the bank always ready.
        @(negedge clk);
        sd_count = 0; last_xfer = -1; spacing_on = 1'b1;
        en = 1'b1; upd_ready = 1'b1;
        expect_steps(6 * SPS);
        wait_drain("sweep");
        spacing_on = 1'b0;
        check("sweep_end_word", dut_word(), exp_word(0, 0));
        check("sweep_sector_done_cnt", sd_count, 6);
        check("sweep_no_overflow", int'(ovf), 0);

        // Backpressure across a terminal count.
        expect_steps(1);
        upd_ready = 1'b0;
        wait_valid("stall");
        repeat (10) @(negedge clk);
        check("stall_valid", int'(upd_valid), 1);
        check("stall_word", dut_word(), exp_word(m_sec, m_st));
        expect_steps(1);
        upd_ready = 1'b1;
        @(negedge clk);
        check("stall_release_word", dut_word(), exp_word(m_sec, m_st));
        check("stall_release_valid", int'(upd_valid), 1);
        expect_steps(1);
        repeat (3) @(negedge clk);
        check("stall_gap_hold", dut_word(), exp_word(0, 2));
        @(negedge clk);
        check("stall_gap_step", dut_word(), exp_word(0, 3));
        wait_drain("stall");

        // Restart at sector 3, step 2.
        while (!(m_sec == 3 && m_st == 2)) expect_steps(1);
        wait_drain("to_s3");
        check("pre_restart_sector", int'(sector), 3);
        m_sec = 0; m_st = 0;
        exp_q.push_back(exp_word(0, 0));
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("restart_word", dut_word(), exp_word(0, 0));
        check("restart_valid", int'(upd_valid), 1);
        expect_steps(2);
        wait_drain("restart");

        // Disable with an update pending: handshake completes, sweep freezes.
        upd_ready = 1'b0;
        expect_steps(1);
        wait_valid("freeze");
        en = 1'b0;
        repeat (8) @(negedge clk);
        check("freeze_valid", int'(upd_valid), 1);
        check("freeze_word", dut_word(), exp_word(m_sec, m_st));
        upd_ready = 1'b1;
        @(negedge clk);
        check("freeze_accept_valid", int'(upd_valid), 0);
        repeat (6) @(negedge clk);
        check("frozen_word", dut_word(), exp_word(0, 3));
        check("frozen_valid", int'(upd_valid), 0);
        expect_steps(1);
        en = 1'b1;
        repeat (4) @(negedge clk);
        check("reen_hold", dut_word(), exp_word(0, 3));
        @(negedge clk);
        check("reen_step", dut_word(), exp_word(1, 0));
        wait_drain("reen");

        // Reset in the middle of a handshake drops valid at once.
        upd_ready = 1'b0;
        expect_steps(1);
        wait_valid("rst_mid");
        rst = 1'b1;
        #1;
        check("rst_mid_valid", int'(upd_valid), 0);
        check("rst_mid_word", dut_word(), exp_word(0, 0));
        exp_q.delete();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
